// File: rtl/test_frame_gen_if.sv
// test_frame_gen_if: Ethernet header plus payload AXI-stream bundle between the frame source and the TX path
interface test_frame_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic                  hdr_valid;
   logic                  hdr_ready;
   logic [47:0]           dest_mac;
   logic [47:0]           src_mac;
   logic [15:0]           eth_type;
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;
   modport master (
      output hdr_valid, dest_mac, src_mac, eth_type, tdata, tkeep, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );
   modport slave (
      input  hdr_valid, dest_mac, src_mac, eth_type, tdata, tkeep, tvalid, tlast, tuser,
      output hdr_ready, tready
   );
endinterface

// File: rtl/test_frame_gen.sv
// test_frame_gen: sequence-numbered Ethernet test-frame source; TEST_FRAME_GEN_ERR_INJECT_EN adds tuser error injection and err_count
module test_frame_gen #(
   parameter int          DATA_WIDTH  = 8,
   parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int          KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int          LEN_WIDTH   = 16,
   parameter int          GAP_WIDTH   = 16,
   parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_00,
   parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_00,
   parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic [GAP_WIDTH-1:0] frame_gap,
   input  logic [31:0]          frame_limit,
   input  logic                 err_inject,
   test_frame_gen_if.master     m,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          frame_count,
   output logic [31:0]          byte_count
`ifdef TEST_FRAME_GEN_ERR_INJECT_EN
   ,
   output logic [31:0]          err_count
`endif
);
   localparam int IW = LEN_WIDTH + 1;
   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, GAP, DONE} state_t;
   state_t                state, state_nx;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [IW-1:0]         idx, bidx;
   logic [GAP_WIDTH-1:0]  gap_q, gap_cnt;
   logic [31:0]           seq;
   logic                  hdr_hs, pay_hs, end_hs, run_start, inj, beat_last;
   logic [DATA_WIDTH-1:0] beat_data;
   logic [KEEP_WIDTH-1:0] beat_keep;

   function automatic logic [7:0] pat(input logic [IW-1:0] b, input logic [31:0] s);
      logic [31:0] sh;
      sh = s >> {~b[1:0], 3'b000};
      return (b < IW'(4)) ? sh[7:0] : b[7:0];
   endfunction

   assign m.dest_mac = DST_MAC;
   assign m.src_mac  = LOCAL_MAC;
   assign m.eth_type = ETH_TYPE;
   assign hdr_hs     = m.hdr_valid & m.hdr_ready;
   assign pay_hs     = m.tvalid & m.tready;
   assign end_hs     = pay_hs & m.tlast;
   assign run_start  = (state == IDLE) & enable;
   assign bidx       = (state == HDR) ? '0 : idx + IW'(KEEP_WIDTH);

`ifdef TEST_FRAME_GEN_ERR_INJECT_EN
   logic err_armed, err_frame;
   assign inj = (state == HDR) ? err_armed : err_frame;
   // Sticky injection request, flag for the frame carrying it, and injected-frame count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_armed <= 1'b0;
         err_frame <= 1'b0;
         err_count <= '0;
      end else begin
         err_armed <= (err_armed & ~(end_hs & err_frame)) | err_inject;
         if (hdr_hs) err_frame <= err_armed;
         else if (end_hs) err_frame <= 1'b0;
         if (run_start) err_count <= '0;
         else if (end_hs & err_frame) err_count <= err_count + 32'd1;
      end
   end
`else
   logic unused_err;
   assign unused_err = err_inject;
   assign inj = 1'b0;
`endif

   // Contents of the beat about to be presented: lane k carries pattern byte bidx+k
   always_comb begin
      beat_data = '0;
      beat_keep = '1;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
         beat_data[8*k +: 8] = pat(bidx + IW'(k), seq);
         if (KEEP_ENABLE) beat_keep[k] = (bidx + IW'(k)) < {1'b0, len_q};
      end
      beat_last = (bidx + IW'(KEEP_WIDTH)) >= {1'b0, len_q};
   end

   // Next-state: a started frame always runs to tlast before enable is honoured
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable) state_nx = HDR;
         HDR:     if (hdr_hs) state_nx = PAYLOAD;
         PAYLOAD: if (end_hs) state_nx = (frame_limit != '0 && frame_count + 32'd1 == frame_limit) ? DONE :
                                         !enable ? IDLE : (gap_q == '0) ? HDR : GAP;
         GAP:     if (gap_cnt == '0) state_nx = enable ? HDR : IDLE;
         DONE:    if (!enable) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   // Registered outputs, beat pipeline, latched config and run counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m.hdr_valid <= 1'b0;
         m.tvalid    <= 1'b0;
         m.tlast     <= 1'b0;
         m.tuser     <= 1'b0;
         m.tdata     <= '0;
         m.tkeep     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         idx         <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         gap_cnt     <= '0;
         seq         <= '0;
         frame_count <= '0;
         byte_count  <= '0;
      end else begin
         m.hdr_valid <= state_nx == HDR;
         m.tvalid    <= state_nx == PAYLOAD;
         busy        <= state_nx inside {HDR, PAYLOAD, GAP};
         done        <= state_nx == DONE;
         if (state_nx == HDR && state != HDR) begin
            len_q <= (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
            gap_q <= frame_gap;
         end
         if (state_nx == GAP && state != GAP) gap_cnt <= gap_q - GAP_WIDTH'(1);
         else if (state == GAP) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
         if (hdr_hs || (pay_hs && !m.tlast)) begin
            idx     <= bidx;
            m.tdata <= beat_data;
            m.tkeep <= beat_keep;
            m.tlast <= beat_last;
            m.tuser <= beat_last & inj;
         end else if (end_hs) begin
            m.tlast <= 1'b0;
            m.tuser <= 1'b0;
         end
         if (run_start) begin
            frame_count <= '0;
            byte_count  <= '0;
            seq         <= '0;
         end else if (end_hs) begin
            frame_count <= frame_count + 32'd1;
            seq         <= seq + 32'd1;
            byte_count  <= byte_count + 32'(len_q);
         end
      end
   end
endmodule

// File: tb/tb_test_frame_gen.sv
// tb_test_frame_gen: randomized self-checking bench for test_frame_gen (32-bit payload) against a byte-level reference model
module tb_test_frame_gen;
   localparam int DW = 32;
   localparam int KW = 4;
`ifdef TEST_FRAME_GEN_ERR_INJECT_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, err_inject = 1'b0;
   logic [15:0] frame_len = '0, frame_gap = '0;
   logic [31:0] frame_limit = '0;
   logic        busy, done;
   logic [31:0] frame_count, byte_count;
`ifdef TEST_FRAME_GEN_ERR_INJECT_EN
   logic [31:0] err_count;
`endif

   test_frame_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus();

   test_frame_gen #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_len(frame_len), .frame_gap(frame_gap),
      .frame_limit(frame_limit), .err_inject(err_inject), .m(bus), .busy(busy), .done(done),
      .frame_count(frame_count), .byte_count(byte_count)
`ifdef TEST_FRAME_GEN_ERR_INJECT_EN
      , .err_count(err_count)
`endif
   );

   always #4 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
      int            cyc;
   } beat_t;

   int          vectors = 0, miscompares = 0;
   beat_t       beats[$];
   logic [7:0]  bytes[$];
   int          hv_rise[$];
   int          hdr_hs, unstable, overlap, timeout, done_cyc;

   // Reference payload byte b of frame f within a run (sequence number equals frame index)
   function automatic logic [7:0] exp_byte(input int f, input int b);
      logic [31:0] s;
      s = f;
      return (b < 4) ? s[31-8*b -: 8] : 8'(b);
   endfunction

   task automatic start_run(input int len, input int gap, input int limit);
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      frame_len = 16'(len);
      frame_gap = 16'(gap);
      frame_limit = 32'(limit);
      enable = 1'b1;
   endtask

   // Drives ready/err_inject each cycle and records everything the DUT emits until it leaves the busy states
   task automatic collect(input int max_cyc, input bit bp, input int drop_at, input int inj_frame);
      logic prev_hv, prev_tv, prev_rd, pl;
      logic [DW-1:0] pd;
      logic [KW-1:0] pk;
      int pulses;
      beats.delete(); bytes.delete(); hv_rise.delete();
      hdr_hs = 0; unstable = 0; overlap = 0; timeout = 1; done_cyc = -1;
      prev_hv = 0; prev_tv = 0; prev_rd = 0; pl = 0; pd = '0; pk = '0; pulses = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (c == drop_at) enable = 1'b0;
         err_inject = 1'b0;
         if (inj_frame >= 0 && hdr_hs == inj_frame + 1 && bus.tvalid && pulses < 3) begin
            err_inject = (pulses != 1);
            pulses++;
         end
         bus.hdr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.tready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.hdr_valid && !prev_hv) hv_rise.push_back(c);
         if (bus.hdr_valid && bus.tvalid) overlap++;
         if (prev_tv && !prev_rd && bus.tvalid && {bus.tdata, bus.tkeep, bus.tlast} !== {pd, pk, pl}) unstable++;
         if (bus.hdr_valid && bus.hdr_ready) hdr_hs++;
         if (bus.tvalid && bus.tready) begin
            beats.push_back('{bus.tdata, bus.tkeep, bus.tlast, bus.tuser, c});
            for (int k = 0; k < KW; k++) if (bus.tkeep[k]) bytes.push_back(bus.tdata[8*k +: 8]);
         end
         prev_hv = bus.hdr_valid; prev_tv = bus.tvalid; prev_rd = bus.tready;
         pd = bus.tdata; pk = bus.tkeep; pl = bus.tlast;
         if (done || !busy) begin
            done_cyc = c;
            timeout = 0;
            break;
         end
      end
      err_inject = 1'b0;
      bus.hdr_ready = 1'b1;
      bus.tready = 1'b1;
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if ({bus.hdr_valid, bus.tvalid, bus.tlast, bus.tuser, busy, done} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 000000", {bus.hdr_valid, bus.tvalid, bus.tlast, bus.tuser, busy, done});
      end
      vectors++;
      if ({bus.tdata, bus.tkeep, frame_count, byte_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %0d %0d want all zero", bus.tdata, bus.tkeep, frame_count, byte_count);
      end
      vectors++;
      if ({bus.dest_mac, bus.src_mac, bus.eth_type} !== {48'h020000000000, 48'h020000000000, 16'h88B5}) begin
         miscompares++;
         $display("FAIL reset_hdr_fields: got %h %h %h", bus.dest_mac, bus.src_mac, bus.eth_type);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] exp_b[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h05};
      logic [KW-1:0] exp_k[4] = '{4'hF, 4'h3, 4'hF, 4'h3};
      start_run(6, 0, 2);
      collect(200, 1'b0, -1, -1);
      vectors++;
      if (timeout !== 0 || bytes.size() != 12 || beats.size() != 4) begin
         miscompares++;
         $display("FAIL basic_shape: timeout %0d bytes %0d beats %0d want 0 12 4", timeout, bytes.size(), beats.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            vectors++;
            if (bytes[i] !== exp_b[i]) begin
               miscompares++;
               $display("FAIL basic_byte[%0d]: got %h want %h", i, bytes[i], exp_b[i]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({beats[i].keep, beats[i].last, beats[i].user} !== {exp_k[i], 1'(i % 2), 1'b0}) begin
               miscompares++;
               $display("FAIL basic_beat[%0d]: keep/last/user %h/%b/%b want %h/%b/0", i, beats[i].keep, beats[i].last, beats[i].user, exp_k[i], 1'(i % 2));
            end
         end
         vectors++;
         if (hv_rise.size() != 2 || hv_rise[1] - beats[1].cyc != 1) begin
            miscompares++;
            $display("FAIL basic_back_to_back: hdr rises %0d want 2 with zero idle cycles", hv_rise.size());
         end
      end
      vectors++;
      if ({done, frame_count, byte_count} !== {1'b1, 32'd2, 32'd12}) begin
         miscompares++;
         $display("FAIL basic_counts: done %b frames %0d bytes %0d want 1 2 12", done, frame_count, byte_count);
      end
   endtask

   task automatic test_tkeep;
      start_run(10, 0, 1);
      collect(200, 1'b0, -1, -1);
      vectors++;
      if (timeout !== 0 || beats.size() != 3) begin
         miscompares++;
         $display("FAIL tkeep_beats: timeout %0d beats %0d want 0 3", timeout, beats.size());
      end else begin
         vectors++;
         if ({beats[0].keep, beats[1].keep, beats[2].keep} !== 12'hFF3) begin
            miscompares++;
            $display("FAIL tkeep_pattern: got %h %h %h want f f 3", beats[0].keep, beats[1].keep, beats[2].keep);
         end
         vectors++;
         if ({beats[0].last, beats[1].last, beats[2].last} !== 3'b001) begin
            miscompares++;
            $display("FAIL tkeep_tlast: got %b%b%b want 001", beats[0].last, beats[1].last, beats[2].last);
         end
         vectors++;
         if (beats[2].data[15:0] !== 16'h0908) begin
            miscompares++;
            $display("FAIL tkeep_last_data: got %h want 0908", beats[2].data[15:0]);
         end
      end
      vectors++;
      if (byte_count !== 32'd10) begin
         miscompares++;
         $display("FAIL tkeep_bytes: got %0d want 10", byte_count);
      end
   endtask

   task automatic test_gap;
      int lc[$];
      start_run(6, 5, 3);
      collect(300, 1'b0, -1, -1);
      foreach (beats[i]) if (beats[i].last) lc.push_back(beats[i].cyc);
      vectors++;
      if (timeout !== 0 || lc.size() != 3 || hv_rise.size() != 3) begin
         miscompares++;
         $display("FAIL gap_shape: timeout %0d frames %0d hdrs %0d want 0 3 3", timeout, lc.size(), hv_rise.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (hv_rise[i+1] - lc[i] - 1 != 5) begin
               miscompares++;
               $display("FAIL gap_idle[%0d]: got %0d idle cycles want 5", i, hv_rise[i+1] - lc[i] - 1);
            end
         end
         vectors++;
         if (done_cyc - lc[2] != 1) begin
            miscompares++;
            $display("FAIL gap_final_done: got %0d cycles want 1", done_cyc - lc[2]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] ref_b[$];
      start_run(64, 0, 20);
      collect(2000, 1'b0, -1, -1);
      ref_b = bytes;
      start_run(64, 0, 20);
      collect(8000, 1'b1, -1, -1);
      vectors++;
      if ({timeout, unstable, overlap, hdr_hs} !== {32'd0, 32'd0, 32'd0, 32'd20}) begin
         miscompares++;
         $display("FAIL bp_protocol: timeout %0d unstable %0d overlap %0d hdrs %0d want 0 0 0 20", timeout, unstable, overlap, hdr_hs);
      end
      vectors++;
      if (bytes.size() != 1280 || ref_b.size() != 1280) begin
         miscompares++;
         $display("FAIL bp_size: got %0d / %0d bytes want 1280", bytes.size(), ref_b.size());
      end else begin
         for (int i = 0; i < 1280; i++) begin
            vectors++;
            if (bytes[i] !== exp_byte(i / 64, i % 64) || ref_b[i] !== exp_byte(i / 64, i % 64)) begin
               miscompares++;
               $display("FAIL bp_byte[%0d]: got %h / %h want %h", i, bytes[i], ref_b[i], exp_byte(i / 64, i % 64));
            end
         end
      end
      vectors++;
      if ({frame_count, byte_count} !== {32'd20, 32'd1280}) begin
         miscompares++;
         $display("FAIL bp_counts: frames %0d bytes %0d want 20 1280", frame_count, byte_count);
      end
   endtask

   task automatic test_enable_drop;
      int hv_seen;
      start_run(100, 0, 0);
      collect(500, 1'b0, 10, -1);
      vectors++;
      if (timeout !== 0 || beats.size() != 25 || hdr_hs != 1) begin
         miscompares++;
         $display("FAIL drop_shape: timeout %0d beats %0d hdrs %0d want 0 25 1", timeout, beats.size(), hdr_hs);
      end else begin
         vectors++;
         if (beats[24].last !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_tlast: got %b want 1", beats[24].last);
         end
         for (int i = 0; i < 100; i++) begin
            vectors++;
            if (bytes[i] !== exp_byte(0, i)) begin
               miscompares++;
               $display("FAIL drop_byte[%0d]: got %h want %h", i, bytes[i], exp_byte(0, i));
            end
         end
      end
      hv_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.hdr_valid || busy || done) hv_seen++;
      end
      vectors++;
      if (hv_seen != 0) begin
         miscompares++;
         $display("FAIL drop_idle: got %0d active cycles want 0", hv_seen);
      end
      vectors++;
      if ({frame_count, byte_count} !== {32'd1, 32'd100}) begin
         miscompares++;
         $display("FAIL drop_counts: frames %0d bytes %0d want 1 100", frame_count, byte_count);
      end
   endtask

   task automatic test_reset_mid;
      start_run(20, 0, 0);
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.hdr_valid, bus.tvalid, bus.tlast, bus.tuser, busy, done} !== 6'b0) begin
         miscompares++;
         $display("FAIL rstmid_flags: got %b want 000000", {bus.hdr_valid, bus.tvalid, bus.tlast, bus.tuser, busy, done});
      end
      vectors++;
      if ({bus.tdata, bus.tkeep} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_data: got %h %h want 0 0", bus.tdata, bus.tkeep);
      end
      vectors++;
      if ({frame_count, byte_count} !== 64'd0) begin
         miscompares++;
         $display("FAIL rstmid_counts: frames %0d bytes %0d want 0 0", frame_count, byte_count);
      end
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_short;
      int lens[4] = '{0, 1, 4, 5};
      for (int i = 0; i < 4; i++) begin
         int l = (lens[i] == 0) ? 1 : lens[i];
         int nb = (l + KW - 1) / KW;
         start_run(lens[i], 0, 1);
         collect(100, 1'b0, -1, -1);
         vectors++;
         if (timeout !== 0 || beats.size() != nb || bytes.size() != l) begin
            miscompares++;
            $display("FAIL short_len%0d_shape: beats %0d bytes %0d want %0d %0d", lens[i], beats.size(), bytes.size(), nb, l);
         end else begin
            vectors++;
            if ({beats[nb-1].keep, beats[nb-1].last, beats[0].last} !== {KW'((1 << (l - KW * (nb - 1))) - 1), 1'b1, 1'(nb == 1)}) begin
               miscompares++;
               $display("FAIL short_len%0d_last: keep %h last %b first_last %b", lens[i], beats[nb-1].keep, beats[nb-1].last, beats[0].last);
            end
         end
         vectors++;
         if (byte_count !== 32'(l)) begin
            miscompares++;
            $display("FAIL short_len%0d_bytes: got %0d want %0d", lens[i], byte_count, l);
         end
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         int l = $urandom_range(1, 40);
         int g = $urandom_range(0, 3);
         int n = $urandom_range(1, 4);
         bit bp = 1'($urandom_range(0, 1));
         int nb = (l + KW - 1) / KW;
         int lc[$];
         start_run(l, g, n);
         collect(3000, bp, -1, -1);
         vectors++;
         if (timeout !== 0 || bytes.size() != l * n || beats.size() != nb * n || hv_rise.size() != n) begin
            miscompares++;
            $display("FAIL rand%0d_shape: timeout %0d bytes %0d beats %0d hdrs %0d (len %0d frames %0d)", r, timeout, bytes.size(), beats.size(), hv_rise.size(), l, n);
         end else begin
            for (int i = 0; i < l * n; i++) begin
               vectors++;
               if (bytes[i] !== exp_byte(i / l, i % l)) begin
                  miscompares++;
                  $display("FAIL rand%0d_byte[%0d]: got %h want %h", r, i, bytes[i], exp_byte(i / l, i % l));
               end
            end
            foreach (beats[i]) begin
               logic el;
               logic [KW-1:0] ek;
               el = (i % nb) == nb - 1;
               ek = el ? KW'((1 << (l - KW * (nb - 1))) - 1) : '1;
               if (beats[i].last) lc.push_back(beats[i].cyc);
               vectors++;
               if ({beats[i].keep, beats[i].last, beats[i].user} !== {ek, el, 1'b0}) begin
                  miscompares++;
                  $display("FAIL rand%0d_beat[%0d]: keep/last/user %h/%b/%b want %h/%b/0", r, i, beats[i].keep, beats[i].last, beats[i].user, ek, el);
               end
            end
            for (int i = 0; i + 1 < n && i < lc.size(); i++) begin
               vectors++;
               if (hv_rise[i+1] - lc[i] - 1 != g) begin
                  miscompares++;
                  $display("FAIL rand%0d_gap[%0d]: got %0d idle cycles want %0d", r, i, hv_rise[i+1] - lc[i] - 1, g);
               end
            end
         end
         vectors++;
         if ({done, frame_count, byte_count} !== {1'b1, 32'(n), 32'(l * n)}) begin
            miscompares++;
            $display("FAIL rand%0d_counts: done %b frames %0d bytes %0d want 1 %0d %0d", r, done, frame_count, byte_count, n, l * n);
         end
      end
   endtask

   task automatic test_err_inject;
      start_run(16, 1, 6);
      collect(400, 1'b0, -1, 3);
      vectors++;
      if (timeout !== 0 || beats.size() != 24) begin
         miscompares++;
         $display("FAIL err_shape: timeout %0d beats %0d want 0 24", timeout, beats.size());
      end else begin
         foreach (beats[i]) begin
            logic eu;
            eu = ERR && (i / 4 == 4) && beats[i].last;
            vectors++;
            if (beats[i].user !== eu) begin
               miscompares++;
               $display("FAIL err_tuser[%0d]: got %b want %b", i, beats[i].user, eu);
            end
         end
      end
`ifdef TEST_FRAME_GEN_ERR_INJECT_EN
      vectors++;
      if (err_count !== 32'd1) begin
         miscompares++;
         $display("FAIL err_count: got %0d want 1", err_count);
      end
`endif
   endtask

   initial begin
      bus.hdr_ready = 1'b1;
      bus.tready = 1'b1;
      test_reset();
      test_basic();
      test_tkeep();
      test_gap();
      test_short();
      test_backpressure();
      test_random();
      test_enable_drop();
      test_err_inject();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
